// File: rtl/fft_frame_scheduler_if.sv
// rtl/fft_frame_scheduler_if.sv - FIFO read side, window stream and FFT completion bundle for the frame scheduler.
interface fft_frame_scheduler_if #(
    parameter int W = 16
);
    logic         buf_full;
    logic [W-1:0] buf_data;
    logic         buf_read;
    logic         overrun;
    logic         win_ready;
    logic         win_valid;
    logic [W-1:0] win_data;
    logic         win_sop;
    logic         win_eop;
    logic         fft_done;

    modport master (
        input  buf_full, buf_data, overrun, win_ready, fft_done,
        output buf_read, win_valid, win_data, win_sop, win_eop
    );

    modport slave (
        output buf_full, buf_data, overrun, win_ready, fft_done,
        input  buf_read, win_valid, win_data, win_sop, win_eop
    );
endinterface

// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - moves one full FIFO frame into the window/FFT chain, gated on FFT completion.
module fft_frame_scheduler #(
    parameter int W        = 16,
    parameter int NSamples = 1024,
    parameter int TIMEOUT  = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    fft_frame_scheduler_if.master bus,
    output logic                  busy,
    output logic [1:0]            state,
    output logic [15:0]           frame_count,
    output logic [15:0]           overrun_count,
    output logic                  timeout_err
);
    localparam int CW = $clog2(NSamples);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NSamples - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FULL = 2'd1,
        STREAM    = 2'd2,
        WAIT_FFT  = 2'd3
    } state_t;

    state_t        cur, nxt;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic          ovr_q;
    logic          rd;
    logic          last_rd;
    logic          tmo_hit;

    // Zero-latency passthrough: the show-ahead FIFO word goes straight to the window.
    assign rd            = (cur == STREAM) && bus.win_ready;
    assign last_rd       = rd && (cnt == LAST_IDX);
    assign bus.buf_read  = rd;
    assign bus.win_valid = rd;
    assign bus.win_data  = bus.buf_data;
    assign bus.win_sop   = rd && (cnt == '0);
    assign bus.win_eop   = last_rd;
    assign busy          = (cur == STREAM) || (cur == WAIT_FFT);
    assign state         = cur;

    always_comb begin
        nxt     = cur;
        tmo_hit = 1'b0;
        case (cur)
            IDLE:      if (enable) nxt = WAIT_FULL;
            WAIT_FULL: begin
                if (!enable)           nxt = IDLE;
                else if (bus.buf_full) nxt = STREAM;
            end
            STREAM:    if (last_rd) nxt = WAIT_FFT;
            WAIT_FFT: begin
                // fft_done takes priority over a timeout landing in the same cycle.
                if (bus.fft_done || (tcnt == TMO_LAST)) begin
                    nxt     = enable ? WAIT_FULL : IDLE;
                    tmo_hit = !bus.fft_done;
                end
            end
            default:   nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur           <= IDLE;
            cnt           <= '0;
            tcnt          <= '0;
            frame_count   <= '0;
            overrun_count <= '0;
            timeout_err   <= 1'b0;
            ovr_q         <= 1'b0;
        end else begin
            cur   <= nxt;
            ovr_q <= bus.overrun;
            if ((cur == WAIT_FULL) && (nxt == STREAM)) cnt <= '0;
            else if (rd)                               cnt <= cnt + 1'b1;
            if (cur != WAIT_FFT) tcnt <= '0;
            else                 tcnt <= tcnt + 1'b1;
            if (last_rd) frame_count <= frame_count + 16'd1;
            if (bus.overrun && !ovr_q && (overrun_count != 16'hFFFF))
                overrun_count <= overrun_count + 16'd1;
            if (tmo_hit) timeout_err <= 1'b1;
        end
    end
endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Sequences one audio frame at a time from the async input FIFO (read side) into the Hanning window / FFT chain.
- Waits for the FIFO to fill, then drains exactly NSamples words with sop/eop framing under window backpressure.
- Holds off the next frame until the FFT reports completion or a timeout expires.
- Keeps frame, overrun and timeout status for the control/debug registers.

Parameters:
- W, 16: sample width in bits.
- NSamples, 1024: samples per frame; power of two, at least 4.
- TIMEOUT, 65535: clk cycles allowed in WAIT_FFT before abandoning the wait; must be at least 1.

Ports:
- clk  input  1  system clock; FIFO read side and window/FFT domain.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  level; permits starting new frames.
- buf_full  input  1  FIFO rdfull.
- buf_data  input  W  FIFO q; show-ahead, valid in the cycle buf_read is high.
- buf_read  output  1  FIFO rdreq.
- overrun  input  1  FIFO write-full, already synchronised to clk.
- win_ready  input  1  window accepts a sample this cycle.
- win_valid  output  1  sample valid to window.
- win_data  output  W  sample to window.
- win_sop  output  1  first sample of frame.
- win_eop  output  1  last sample of frame.
- fft_done  input  1  single-cycle pulse when the FFT has finished outputting a frame.
- busy  output  1  high in STREAM or WAIT_FFT.
- state  output  2  IDLE=0, WAIT_FULL=1, STREAM=2, WAIT_FFT=3.
- frame_count  output  16  frames fully streamed; wraps.
- overrun_count  output  16  rising edges of overrun; saturates at 0xFFFF.
- timeout_err  output  1  sticky; set on FFT timeout.

Behaviour:
- Reset (reset=0, async assert; synchronous release on clk): state=IDLE, sample counter=0, timeout counter=0, frame_count=0, overrun_count=0, timeout_err=0, overrun edge register=0. All outputs 0; win_data follows buf_data.
- Datapath is combinational, zero latency:
  - buf_read = (state==STREAM) && win_ready.
  - win_valid = buf_read; win_data = buf_data.
  - win_sop = buf_read && cnt==0.
  - win_eop = buf_read && cnt==NSamples-1.
- Sample counter cnt is $clog2(NSamples) bits. It increments on each buf_read and is cleared on entry to STREAM.
- IDLE: go to WAIT_FULL when enable=1.
- WAIT_FULL: if enable=0, go to IDLE. Else if buf_full=1, go to STREAM with cnt=0.
- STREAM:
  - Stall with no read while win_ready=0.
  - On the read with cnt==NSamples-1: frame_count++, go to WAIT_FFT, timeout counter cleared.
  - enable deasserting mid-frame has no effect; the frame always completes.
  - buf_full dropping mid-frame is not checked; the FIFO cannot underflow, since a full FIFO holds at least NSamples words.
- WAIT_FFT:
  - Timeout counter increments each cycle.
  - fft_done=1: go to WAIT_FULL if enable=1, else IDLE.
  - Timeout counter reaching TIMEOUT-1 without fft_done: set timeout_err, then take the same enable-based transition.
  - fft_done and the timeout in the same cycle: fft_done wins and timeout_err is not set.
- fft_done outside WAIT_FFT is ignored.
- overrun is registered each cycle. A 0->1 transition increments overrun_count (saturating) in every state, including IDLE.
- timeout_err clears only on reset.
- busy = (state==STREAM) || (state==WAIT_FFT).
- Reset asserted mid-frame aborts immediately. The partial frame is not completed and no eop is issued; the FIFO is flushed externally by the same reset.

Test Plan:
- Stream one frame: enable=1, buf_full=1, win_ready=1 constant, NSamples=16 → 16 consecutive buf_read cycles. sop on the first, eop on the 16th, frame_count=1, state=3 next cycle.
- Backpressure: win_ready toggles 1,0,1,0 → buf_read/win_valid only on ready cycles. Exactly 16 reads, sop/eop on the first and last accepted samples; win_data equals buf_data on each.
- Frame gating: after frame 1, assert buf_full but hold fft_done=0 for 50 cycles → no reads. Pulse fft_done → state 1→2 and the second frame streams; frame_count=2.
- Timeout: TIMEOUT=8, no fft_done → after 8 cycles in WAIT_FFT, timeout_err=1 and state=1. A simultaneous fft_done in the final cycle leaves timeout_err=0.
- Enable drop: deassert enable at sample 5 → frame still completes 16 samples. After fft_done, state=IDLE and no further reads.
- Overrun/reset: pulse overrun 3 times → overrun_count=3; hold overrun high for 10 cycles → +1 only. Assert reset at sample 7 → all outputs 0 asynchronously, counters cleared.
